// File: rtl/cpu_pkg.sv
// Shared constants for the 4-bit CPU: opcodes, instruction fields, widths and FSM states.
// The optional carry flag and JC opcode are enabled by defining CPU_CONTROL_CARRY_EN.
package cpu_pkg;
    localparam int DATA_W  = 4;
    localparam int REG_AW  = 2;
    localparam int INSTR_W = 12;

    localparam int OP_HI  = 11;
    localparam int OP_LO  = 8;
    localparam int RD_HI  = 7;
    localparam int RD_LO  = 6;
    localparam int RS_HI  = 5;
    localparam int RS_LO  = 4;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOP  = 4'd0;
    localparam opcode_t OP_LDI  = 4'd1;
    localparam opcode_t OP_MOV  = 4'd2;
    localparam opcode_t OP_ADD  = 4'd3;
    localparam opcode_t OP_SUB  = 4'd4;
    localparam opcode_t OP_JMP  = 4'd5;
    localparam opcode_t OP_JZ   = 4'd6;
    localparam opcode_t OP_HALT = 4'd7;
    localparam opcode_t OP_JC   = 4'd8;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    function automatic logic writes_reg(input opcode_t op);
        return (op == OP_LDI) || (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB);
    endfunction
endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the 4-bit CPU; all arithmetic is modulo 2^DATA_W.
// With CPU_CONTROL_CARRY_EN defined it also reports carry-out (ADD) or borrow (SUB).
module cpu_alu
    import cpu_pkg::*;
(
    input  opcode_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
`ifdef CPU_CONTROL_CARRY_EN
    output logic              carry,
`endif
    output logic [DATA_W-1:0] result
);
`ifdef CPU_CONTROL_CARRY_EN
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    assign sum  = {1'b0, a} + {1'b0, b};
    // The extra MSB of the widened difference is set exactly when a < b.
    assign diff = {1'b0, a} - {1'b0, b};
    assign carry = (op == OP_SUB) ? diff[DATA_W] : sum[DATA_W];
`else
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    assign sum  = a + b;
    assign diff = a - b;
`endif

    always_comb begin
        result = '0;
        case (op)
            OP_LDI:  result = imm;
            OP_MOV:  result = b;
            OP_ADD:  result = sum[DATA_W-1:0];
            OP_SUB:  result = diff[DATA_W-1:0];
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/cpu_control.sv
// Four-cycle fetch/decode/execute/writeback controller driving the register file.
// Defining CPU_CONTROL_CARRY_EN adds a carry flag and the JC opcode (8).
module cpu_control
    import cpu_pkg::*;
#(
    parameter int PC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [REG_AW-1:0]  ra,
    output logic [REG_AW-1:0]  rb,
    input  logic [DATA_W-1:0]  rdata_a,
    input  logic [DATA_W-1:0]  rdata_b,
    output logic [REG_AW-1:0]  wa,
    output logic [DATA_W-1:0]  wd,
    output logic               we,
    output logic [PC_W-1:0]    pc,
    output logic               halted,
    output state_t             state
);
    state_t              state_nxt;
    logic [PC_W-1:0]     pc_nxt;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   result;
    logic [DATA_W-1:0]   alu_result;
    logic                taken;
    logic                branch_now;
    logic                we_q;
    opcode_t             op;
    logic [DATA_W-1:0]   imm;

    assign op  = ir[OP_HI:OP_LO];
    assign imm = ir[IMM_HI:IMM_LO];

    // Register addresses come straight from IR, so they stay stable from DECODE through WB.
    assign ra        = ir[RD_HI:RD_LO];
    assign rb        = ir[RS_HI:RS_LO];
    assign wa        = ir[RD_HI:RD_LO];
    assign wd        = result;
    assign we        = we_q;
    assign imem_addr = pc;
    assign halted    = (state == ST_HALT);

`ifdef CPU_CONTROL_CARRY_EN
    logic carry_flag;
    logic alu_carry;

    cpu_alu u_alu (
        .op     (op),
        .a      (rdata_a),
        .b      (rdata_b),
        .imm    (imm),
        .carry  (alu_carry),
        .result (alu_result)
    );

    assign branch_now = (op == OP_JMP)
                     || ((op == OP_JZ) && (rdata_a == '0))
                     || ((op == OP_JC) && carry_flag);

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_flag <= 1'b0;
        end else if ((state == ST_EXEC) && ((op == OP_ADD) || (op == OP_SUB))) begin
            carry_flag <= alu_carry;
        end
    end
`else
    cpu_alu u_alu (
        .op     (op),
        .a      (rdata_a),
        .b      (rdata_b),
        .imm    (imm),
        .result (alu_result)
    );

    assign branch_now = (op == OP_JMP) || ((op == OP_JZ) && (rdata_a == '0));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_FETCH;
            pc     <= '0;
            ir     <= '0;
            result <= '0;
            taken  <= 1'b0;
            we_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if ((state == ST_FETCH) && run) begin
                ir <= imem_data;
            end
            if (state == ST_EXEC) begin
                result <= alu_result;
                taken  <= branch_now;
            end
            // Set on the EXEC->WB edge only, giving a one-cycle pulse aligned with WB.
            we_q <= (state == ST_EXEC) && writes_reg(op);
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            ST_FETCH:  if (run) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC:   state_nxt = ST_WB;
            ST_WB: begin
                if (op == OP_HALT) begin
                    state_nxt = ST_HALT;
                end else begin
                    state_nxt = ST_FETCH;
                    pc_nxt    = taken ? PC_W'(imm) : pc + PC_W'(1);
                end
            end
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = ST_FETCH;
        endcase
    end
endmodule
